// File: rtl/snake_step_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_step_controller_if
// Description : Step handshake between the step controller and the snake
//               datapath. The controller offers a step (StepValid/StepDir).
//               The datapath accepts it (StepReady), then reports completion
//               (DoneValid) together with the collision result (Collision).
//   master : StepValid, StepDir out; StepReady, DoneValid, Collision in
//   slave  : StepValid, StepDir in;  StepReady, DoneValid, Collision out
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_step_controller_if;
  logic       StepValid;
  logic [1:0] StepDir;
  logic       StepReady;
  logic       DoneValid;
  logic       Collision;

  modport master (
    output StepValid,
    output StepDir,
    input  StepReady,
    input  DoneValid,
    input  Collision
  );

  modport slave (
    input  StepValid,
    input  StepDir,
    output StepReady,
    output DoneValid,
    output Collision
  );
endinterface
`default_nettype wire

// File: rtl/snake_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : snake_step_controller
// Description : Game-step pacing for a snake game. A tick counter derived
//               from BASE_PERIOD and SpeedLevel requests one step per tick
//               from the snake datapath, tracks the direction from button
//               presses and enters a DEAD state on collision.
// Ports       :
//   MasterClock      in   sole clock, rising edge
//   ResetN           in   asynchronous active-low reset
//   SpeedLevel[1:0]  in   step period = BASE_PERIOD >> SpeedLevel
//   Btn[3:0]         in   one-cycle press pulses {Up,Down,Left,Right}
//   Pause            in   freezes stepping when STEP_PAUSE_EN is defined
//   Restart          in   pulse, leaves DEAD
//   stepBus          --   step handshake (master side)
//   Dead             out  high while in DEAD
//   Overrun          out  sticky: tick arrived while a step was outstanding
// Build option: define STEP_PAUSE_EN to make Pause suppress ticks and hold
//               the tick counter; otherwise Pause is ignored.
// Direction codes: 00 Up, 01 Down, 10 Left, 11 Right.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_step_controller #(
  parameter int BASE_PERIOD = 50000000
) (
  input  wire logic                  MasterClock,
  input  wire logic                  ResetN,
  input  wire logic [1:0]            SpeedLevel,
  input  wire logic [3:0]            Btn,
  input  wire logic                  Pause,
  input  wire logic                  Restart,
  snake_step_controller_if.master    stepBus,
  output logic                       Dead,
  output logic                       Overrun
);

  localparam int              CNT_W         = 26;
  localparam logic [CNT_W-1:0] c_basePeriod = CNT_W'(BASE_PERIOD);
  localparam logic [1:0]      c_dirUp       = 2'b00;
  localparam logic [1:0]      c_dirDown     = 2'b01;
  localparam logic [1:0]      c_dirLeft     = 2'b10;
  localparam logic [1:0]      c_dirRight    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_tickCount;
  logic [1:0]       r_curDir;
  logic [1:0]       r_nextDir;
  logic [1:0]       r_stepDir;
  logic             r_overrun;

  logic [1:0]       w_curDirNext;
  logic [1:0]       w_nextDirNext;
  logic [1:0]       w_stepDirNext;
  logic             w_overrunNext;

  logic [CNT_W-1:0] w_periodM1;
  logic             w_paused;
  logic             w_tick;
  logic [1:0]       w_btnDir;
  logic [1:0]       w_refDir;
  logic             w_btnAccept;
  logic [1:0]       w_nextDirPress;
  logic             w_restart;

  // --------------------------------------------------------------------------
  // Tick generation
  // --------------------------------------------------------------------------
`ifdef STEP_PAUSE_EN
  assign w_paused = Pause;
`else
  // Pause is kept on the port for pin compatibility but has no effect.
  assign w_paused = Pause & 1'b0;
`endif

  assign w_periodM1 = (c_basePeriod >> SpeedLevel) - CNT_W'(1);

  // ">=" rather than "==" so that a speed-up that leaves the count beyond
  // the new terminal value still produces a tick and wraps immediately.
  assign w_tick = (r_state != ST_DEAD) && !w_paused &&
                  (r_tickCount >= w_periodM1);

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      r_tickCount <= '0;
    end else if (r_state == ST_DEAD) begin
      r_tickCount <= '0;
    end else if (w_paused) begin
      r_tickCount <= r_tickCount;
    end else if (w_tick) begin
      r_tickCount <= '0;
    end else begin
      r_tickCount <= r_tickCount + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Button decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_btnDir = c_dirRight;
    unique case (Btn)
      4'b1000: w_btnDir = c_dirUp;
      4'b0100: w_btnDir = c_dirDown;
      4'b0010: w_btnDir = c_dirLeft;
      default: w_btnDir = c_dirRight;
    endcase
  end

  // While a step is on offer, the direction about to be committed is the
  // latched StepDir, so presses are judged against it instead of CurDir;
  // this keeps the snake from reversing into itself after the commit.
  assign w_refDir = (r_state == ST_ISSUE) ? r_stepDir : r_curDir;

  // Opposite directions differ only in bit 0 (Up/Down, Left/Right).
  assign w_btnAccept = (r_state != ST_DEAD) && $onehot(Btn) &&
                       (w_btnDir != (w_refDir ^ 2'b01));

  assign w_nextDirPress = w_btnAccept ? w_btnDir : r_nextDir;

  assign w_restart = (r_state == ST_DEAD) && Restart;

  // --------------------------------------------------------------------------
  // FSM: next-state and datapath register updates
  // --------------------------------------------------------------------------
  always_comb begin
    w_stateNext   = r_state;
    w_curDirNext  = r_curDir;
    w_nextDirNext = w_nextDirPress;
    w_stepDirNext = r_stepDir;
    w_overrunNext = r_overrun;

    unique case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_stateNext   = ST_ISSUE;
          // Include a press landing in the tick cycle: latest press wins.
          w_stepDirNext = w_nextDirPress;
        end
      end
      ST_ISSUE: begin
        if (w_tick) begin
          w_overrunNext = 1'b1;
        end
        if (stepBus.StepReady) begin
          w_stateNext  = ST_WAIT;
          w_curDirNext = r_stepDir;
        end
      end
      ST_WAIT: begin
        if (w_tick) begin
          w_overrunNext = 1'b1;
        end
        if (stepBus.DoneValid) begin
          w_stateNext = stepBus.Collision ? ST_DEAD : ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (w_restart) begin
          w_stateNext   = ST_IDLE;
          w_curDirNext  = c_dirRight;
          w_nextDirNext = c_dirRight;
          w_stepDirNext = c_dirRight;
          w_overrunNext = 1'b0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      r_state   <= ST_IDLE;
      r_curDir  <= c_dirRight;
      r_nextDir <= c_dirRight;
      r_stepDir <= c_dirRight;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_curDir  <= w_curDirNext;
      r_nextDir <= w_nextDirNext;
      r_stepDir <= w_stepDirNext;
      r_overrun <= w_overrunNext;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded straight from registers so that reset drops
  // StepValid without waiting for a clock edge.
  // --------------------------------------------------------------------------
  assign stepBus.StepValid = (r_state == ST_ISSUE);
  assign stepBus.StepDir   = r_stepDir;
  assign Dead              = (r_state == ST_DEAD);
  assign Overrun           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_step_controller
// Description : Directed self-checking bench for snake_step_controller with
//               BASE_PERIOD = 8. Plays the datapath side of the step
//               handshake and checks step timing, direction selection,
//               overrun, death/restart, pause and speed change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_step_controller;

  logic       MasterClock = 1'b0;
  logic       ResetN;
  logic [1:0] SpeedLevel;
  logic [3:0] Btn;
  logic       Pause;
  logic       Restart;
  logic       Dead;
  logic       Overrun;

  int nChecks = 0;
  int nFails  = 0;
  int cycleCnt = 0;

  snake_step_controller_if stepBus ();

  snake_step_controller #(
    .BASE_PERIOD (8)
  ) dut (
    .MasterClock (MasterClock),
    .ResetN      (ResetN),
    .SpeedLevel  (SpeedLevel),
    .Btn         (Btn),
    .Pause       (Pause),
    .Restart     (Restart),
    .stepBus     (stepBus),
    .Dead        (Dead),
    .Overrun     (Overrun)
  );

  always #5 MasterClock = ~MasterClock;

  always @(posedge MasterClock) cycleCnt <= cycleCnt + 1;

  task automatic checkEq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge MasterClock);
    #1;
  endtask

  // Advance until StepValid is seen or the bound runs out; n = cycles waited.
  task automatic waitValid(input int bound, output int n);
    n = 0;
    while (stepBus.StepValid !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
  endtask

  // One full datapath transaction: accept at once, report done two cycles
  // after the handshake. Returns the wait latency and the cycle of the offer.
  task automatic doStep(input string tag, input logic [1:0] expDir,
                        input logic collide, output int n, output int rise);
    waitValid(40, n);
    checkEq({tag, "_valid"}, 32'(stepBus.StepValid), 32'd1);
    checkEq({tag, "_dir"}, 32'(stepBus.StepDir), 32'(expDir));
    rise = cycleCnt;
    cyc();
    cyc();
    stepBus.DoneValid = 1'b1;
    stepBus.Collision = collide;
    cyc();
    stepBus.DoneValid = 1'b0;
    stepBus.Collision = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    Btn = b;
    cyc();
    Btn = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r1, r2, bad;

    ResetN            = 1'b0;
    SpeedLevel        = 2'd0;
    Btn               = 4'b0000;
    Pause             = 1'b0;
    Restart           = 1'b0;
    stepBus.StepReady = 1'b1;
    stepBus.DoneValid = 1'b0;
    stepBus.Collision = 1'b0;
    repeat (3) cyc();

    // Reset state
    checkEq("rst_valid",   32'(stepBus.StepValid), 32'd0);
    checkEq("rst_dir",     32'(stepBus.StepDir),   32'd3);
    checkEq("rst_dead",    32'(Dead),              32'd0);
    checkEq("rst_overrun", 32'(Overrun),           32'd0);
    ResetN = 1'b1;

    // Regular stepping: one step every 8 cycles heading Right
    doStep("t1a", 2'b11, 1'b0, n, r1);
    checkEq("t1_firstLat", 32'(n), 32'd8);
    doStep("t1b", 2'b11, 1'b0, n, r2);
    checkEq("t1_period", 32'(r2 - r1), 32'd8);

    // Direction selection
    press(4'b0010);                       // Left opposes Right: rejected
    doStep("t2_leftRej", 2'b11, 1'b0, n, r1);
    press(4'b1000);                       // Up accepted
    press(4'b0010);                       // Left still opposes CurDir Right
    doStep("t2_up", 2'b00, 1'b0, n, r1);
    press(4'b1100);                       // two bits: ignored
    doStep("t2_multi", 2'b00, 1'b0, n, r1);
    press(4'b0100);                       // Down opposes Up: rejected
    doStep("t2_downRej", 2'b00, 1'b0, n, r1);
    press(4'b0001);                       // Right accepted
    doStep("t2_right", 2'b11, 1'b0, n, r1);

    // Backpressure: offer held stable, overrun on the next tick
    stepBus.StepReady = 1'b0;
    waitValid(40, n);
    checkEq("t3_lat", 32'(n), 32'd5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) Btn = 4'b1000;          // press during the offer
      cyc();
      Btn = 4'b0000;
      if (stepBus.StepValid !== 1'b1 || stepBus.StepDir !== 2'b11) bad++;
    end
    checkEq("t3_stable",  32'(bad),     32'd0);
    checkEq("t3_overrun", 32'(Overrun), 32'd1);
    stepBus.StepReady = 1'b1;
    cyc();
    checkEq("t3_validDrop", 32'(stepBus.StepValid), 32'd0);
    cyc();
    stepBus.DoneValid = 1'b1;
    cyc();
    stepBus.DoneValid = 1'b0;
    checkEq("t3_noRequeue", 32'(stepBus.StepValid), 32'd0);

    // Collision, death, restart
    doStep("t4_collide", 2'b00, 1'b1, n, r1);
    checkEq("t4_lat",       32'(n),       32'd1);
    checkEq("t4_dead",      32'(Dead),    32'd1);
    checkEq("t4_ovrSticky", 32'(Overrun), 32'd1);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (stepBus.StepValid !== 1'b0) bad++;
    end
    checkEq("t4_noStepDead", 32'(bad),  32'd0);
    checkEq("t4_stillDead",  32'(Dead), 32'd1);
    Restart = 1'b1;
    cyc();
    Restart = 1'b0;
    checkEq("t4_aliveAgain", 32'(Dead),    32'd0);
    checkEq("t4_ovrCleared", 32'(Overrun), 32'd0);
    doStep("t4_restartDir", 2'b11, 1'b0, n, r1);
    checkEq("t4_restartLat", 32'(n), 32'd8);

    // Pause
    Pause = 1'b1;
`ifdef STEP_PAUSE_EN
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (stepBus.StepValid !== 1'b0) bad++;
    end
    checkEq("t5_noStepPaused", 32'(bad), 32'd0);
    Pause = 1'b0;
    doStep("t5_resume", 2'b11, 1'b0, n, r1);
    checkEq("t5_remainLat", 32'(n), 32'd5);
`else
    doStep("t5_ignored", 2'b11, 1'b0, n, r1);
    checkEq("t5_ignoredLat", 32'(n), 32'd5);
    Pause = 1'b0;
`endif

    // Speed change at count 5: immediate tick, then period 2
    cyc();
    cyc();
    SpeedLevel = 2'd2;
    doStep("t6_fast", 2'b11, 1'b0, n, r1);
    checkEq("t6_fastLat", 32'(n), 32'd1);
    doStep("t6_fast2", 2'b11, 1'b0, n, r2);
    checkEq("t6_stepGap",  32'(r2 - r1), 32'd4);
    checkEq("t6_overrun",  32'(Overrun), 32'd1);

    // Reset while a step is on offer
    stepBus.StepReady = 1'b0;
    waitValid(10, n);
    checkEq("t7_issue", 32'(stepBus.StepValid), 32'd1);
    ResetN = 1'b0;
    #1;
    checkEq("t7_rstValid",   32'(stepBus.StepValid), 32'd0);
    checkEq("t7_rstOverrun", 32'(Overrun),           32'd0);
    checkEq("t7_rstDir",     32'(stepBus.StepDir),   32'd3);
    cyc();
    SpeedLevel        = 2'd0;
    stepBus.StepReady = 1'b1;
    ResetN            = 1'b1;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (stepBus.StepValid !== 1'b0) bad++;
    end
    checkEq("t7_noReissue", 32'(bad), 32'd0);
    doStep("t7_after", 2'b11, 1'b0, n, r1);
    checkEq("t7_afterLat", 32'(n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
